// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor.
//   - FSM state encoding (IDLE/RUN/DONE) and the matching enum type
//   - clog2(): bit-counter width helper
package serial_sub_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_t;

    // Ceiling log2, floored at 1 so a WIDTH=1 counter still has one bit.
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational subtractor cell, x - y - bin.
//   x, y : operand bits     bin  : borrow in
//   d    : difference bit   bout : borrow out
// Built as two cascaded half-subtractors whose borrows are ORed.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1, b1, b2;

    // first half-subtractor: x - y
    assign d1 = x ^ y;
    assign b1 = ~x & y;

    // second half-subtractor: (x - y) - bin
    assign d  = d1 ^ bin;
    assign b2 = ~d1 & bin;

    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit unsigned subtractor, A - B,
// LSB first, one bit per clock through a single full_subtractor cell.
//   clk, rst         : clock, async active-high reset
//   start, a, b      : request and operands (sampled only in IDLE)
//   busy             : high while bits are being processed
//   done             : one-cycle pulse with the final diff/borrow
//   diff, borrow     : result and final borrow (1 iff a < b), held
//   diff_bit         : serial difference bit, qualified by bit_valid
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             diff_bit,
    output logic             bit_valid
);

    localparam int CW = clog2(WIDTH);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa, opb;
    logic             bff;
    logic             d, bout;
    logic             last;

    full_subtractor u_fs (
        .x   (opa[0]),
        .y   (opb[0]),
        .bin (bff),
        .d   (d),
        .bout(bout)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            opa       <= '0;
            opb       <= '0;
            bff       <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            diff_bit  <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opa    <= a;
                        opb    <= b;
                        cnt    <= '0;
                        bff    <= 1'b0;
                        diff   <= '0;
                        borrow <= 1'b0;
                    end
                end
                S_RUN: begin
                    opa       <= opa >> 1;
                    opb       <= opb >> 1;
                    // new bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB
                    diff      <= (diff >> 1) | (WIDTH'(d) << (WIDTH - 1));
                    bff       <= bout;
                    diff_bit  <= d;
                    bit_valid <= 1'b1;
                    cnt       <= cnt + CW'(1);
                    if (last) borrow <= bout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized + directed bench for serial_subtractor.
// Expected results come from plain integer subtraction of the operands.
// Cycle numbering: the accepting clock edge is T0; "cycle T0+n" is the
// clock cycle that ends at edge T0+n, so an output sampled on the negedge
// following edge T0+k belongs to cycle T0+k+1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst8 = 1'b1, start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8, dbit8, bv8;
    logic [7:0] diff8;

    logic       rst1 = 1'b1, start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, borrow1, dbit1, bv1;
    logic [0:0] diff1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8),
        .diff_bit(dbit8), .bit_valid(bv8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1),
        .diff_bit(dbit1), .bit_valid(bv1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation; optionally re-pulse start with a=FF at step poke.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input int poke);
        logic [8:0] full;
        logic [7:0] exp_d;
        logic       exp_b;
        logic [7:0] bits;
        int nb, nbusy, ndone, dk;
        full  = {1'b0, av} - {1'b0, bv};
        exp_d = full[7:0];
        exp_b = (av < bv);
        bits = '0; nb = 0; nbusy = 0; ndone = 0; dk = -1;
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("clr_diff", 32'(diff8), 32'h0);
                chk("clr_borrow", 32'(borrow8), 32'h0);
            end
            if (busy8) nbusy++;
            if (bv8) begin
                if (nb < 8) bits[nb] = dbit8;
                nb++;
            end
            if (done8) begin
                ndone++;
                dk = k;
                chk("diff", 32'(diff8), 32'(exp_d));
                chk("borrow", 32'(borrow8), 32'(exp_b));
                chk("last_bit_with_done", 32'(dbit8), 32'(exp_d[7]));
            end
            if (k == 9) begin
                chk("diff_hold", 32'(diff8), 32'(exp_d));
                chk("borrow_hold", 32'(borrow8), 32'(exp_b));
                chk("idle_busy", 32'(busy8), 32'h0);
            end
            // operand changes outside an accepted start must not matter
            start8 = (poke >= 0 && k == poke);
            a8 = start8 ? 8'hFF : 8'($urandom);
            b8 = 8'($urandom);
        end
        start8 = 1'b0;
        chk("done_count", 32'(ndone), 32'd1);
        chk("done_cycle", 32'(dk + 1), 32'd9);
        chk("busy_cycles", 32'(nbusy), 32'd8);
        chk("bit_count", 32'(nb), 32'd8);
        chk("serial_bits", 32'(bits), 32'(exp_d));
    endtask

    initial begin
        int nd;
        int dpos[$];
        #1;
        chk("rst_busy", 32'(busy8), 32'h0);
        chk("rst_done", 32'(done8), 32'h0);
        chk("rst_diff", 32'(diff8), 32'h0);
        chk("rst_borrow", 32'(borrow8), 32'h0);
        chk("rst_bit_valid", 32'(bv8), 32'h0);
        chk("rst_diff_bit", 32'(dbit8), 32'h0);
        @(negedge clk);
        rst8 = 1'b0;

        // directed cases
        run8(8'h5A, 8'h23, -1);
        run8(8'h00, 8'h01, -1);
        run8(8'hFF, 8'h00, -1);
        run8(8'hA5, 8'hA5, -1);
        run8(8'h10, 8'h01, 2);   // start re-pulsed in RUN cycle 3 is ignored

        // reset in the middle of a run
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        @(negedge clk);
        rst8 = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy8), 32'h0);
        chk("mid_rst_done", 32'(done8), 32'h0);
        chk("mid_rst_diff", 32'(diff8), 32'h0);
        chk("mid_rst_borrow", 32'(borrow8), 32'h0);
        chk("mid_rst_bit_valid", 32'(bv8), 32'h0);
        chk("mid_rst_diff_bit", 32'(dbit8), 32'h0);
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        rst8 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("mid_rst_no_done", 32'(nd), 32'd0);
        run8(8'h03, 8'h05, -1);

        // random operands
        for (int i = 0; i < 20; i++) run8(8'($urandom), 8'($urandom), -1);

        // WIDTH=1: 0-1 with start held from reset release
        a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done1) begin
                dpos.push_back(j);
                chk("w1_diff", 32'(diff1), 32'h1);
                chk("w1_borrow", 32'(borrow1), 32'h1);
                chk("w1_bit", 32'(dbit1), 32'h1);
                chk("w1_bit_valid", 32'(bv1), 32'h1);
            end
        end
        start1 = 1'b0;
        chk("w1_done_count", 32'(dpos.size()), 32'd4);
        if (dpos.size() > 0) chk("w1_done_cycle", 32'(dpos[0] + 1), 32'd2);
        for (int i = 1; i < dpos.size(); i++)
            chk("w1_spacing", 32'(dpos[i] - dpos[i-1]), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing A − B, LSB first, one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the inverse companion of the team's adder primitives: a start/done-handshaked arithmetic unit for area-constrained datapaths. It also exposes each difference bit as it is produced, for serial consumers.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is final.
- diff  output  WIDTH  A − B modulo 2^WIDTH; held until the next accepted start.
- borrow  output  1  final borrow-out; 1 iff A < B (unsigned); held like diff.
- diff_bit  output  1  serial difference bit, LSB first.
- bit_valid  output  1  qualifies diff_bit; high for exactly WIDTH cycles per operation.

## Operation
- State machine:
  - IDLE → RUN on start.
  - RUN → DONE when the bit counter reaches WIDTH−1.
  - DONE → IDLE unconditionally.
- On accepted start:
  - Load a and b into operand shift registers.
  - Clear the borrow flip-flop and bit counter.
  - Clear diff and borrow.
- Each RUN cycle, the cell uses operand LSBs x, y and borrow-in bin:
  - d = x ^ y ^ bin.
  - bout = (~x & y) | (~(x ^ y) & bin).
- Per RUN cycle register updates:
  - Operand registers shift right.
  - d shifts into diff from the MSB side.
  - bout is stored as the next bin.
  - diff_bit = d and bit_valid = 1 on the following cycle.
  - Counter increments.
- On entering DONE:
  - borrow = final bout.
  - diff holds the full result.
  - done = 1 for that single cycle.
- Ignored starts:
  - start in RUN or DONE is ignored and not queued.
  - a and b changes outside an accepted start have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Signed callers interpret diff as two's complement and derive overflow externally.
- WIDTH=1 is legal: RUN lasts one cycle.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, borrow FF 0.
- Start is accepted at edge T0.
- busy is high for cycles T0+1 … T0+WIDTH.
- bit_valid is high for cycles T0+2 … T0+WIDTH+1, carrying bits 0 … WIDTH−1.
- done is high at T0+WIDTH+1, together with the final diff, borrow and the last diff_bit.
- Latency from start to done is WIDTH+1 cycles.
- Minimum start-to-start spacing is WIDTH+2 cycles: DONE returns to IDLE, and the next start can be accepted the cycle after done.
- Reset asserted mid-RUN:
  - Returns to IDLE immediately.
  - Partial result is discarded and all outputs clear.
  - No done is issued.
- start held continuously from reset release runs back-to-back operations with WIDTH+2 spacing.

## Structure
- Package serial_sub_pkg holds:
  - state encoding localparams: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the counter-width function clog2(WIDTH).
- One sub-module, full_subtractor:
  - inputs x, y, bin; outputs d, bout;
  - purely combinational, built from two half-subtractor stages plus an OR;
  - instantiated once.
- Top level holds the FSM, counter, shift registers, borrow FF and output registers.

## Test plan
- WIDTH=8, a=8'h5A, b=8'h23, start for 1 cycle:
  - done exactly 9 cycles after the accepted edge, diff=8'h37, borrow=0.
  - diff_bit sequence 1,1,1,0,1,1,0,0.
- a=8'h00, b=8'h01: diff=8'hFF, borrow=1.
- a=8'hFF, b=8'h00: diff=8'hFF, borrow=0.
- a=b=8'hA5: diff=8'h00, borrow=0.
- Ignored starts:
  - a=8'h10, b=8'h01; pulse start again at cycle 3 with a=8'hFF.
  - Result is 8'h0F, borrow=0, one done only.
  - busy stays high 8 cycles.
- Reset mid-run:
  - Assert rst at RUN cycle 4.
  - Outputs go 0 asynchronously, with no done.
  - A new op 8'h03−8'h05 afterwards gives diff=8'hFE, borrow=1.
- WIDTH=1:
  - 0−1 gives diff=1, borrow=1, done 2 cycles after start.
  - Back-to-back starts are spaced 3 cycles.
